// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, registers the program-memory word for decode,
// handles stall, branch redirect and halt. Optional macro FETCH_PERF_EN adds fetch_count.
module fetch_unit #(
   parameter int                AW       = 8,
   parameter int                IW       = 17,
   parameter int                OPC_W    = 5,
   parameter logic [OPC_W-1:0]  HALT_OPC = 5'h1F,
   parameter logic [AW-1:0]     RESET_PC = 8'h00
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           stall,
   input  logic           branch_take,
   input  logic [AW-1:0]  branch_target,
   output logic [AW-1:0]  pc_addr,
   input  logic [IW-1:0]  instr_in,
   output logic [IW-1:0]  instr_out,
   output logic [AW-1:0]  pc_out,
   output logic           instr_valid,
   output logic           halted
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]    fetch_count
`endif
);

   typedef enum logic {
      S_FETCH = 1'b0,
      S_HALT  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    pc_q, pc_d;
   logic [IW-1:0]    instr_q, instr_d;
   logic [AW-1:0]    pc_out_q, pc_out_d;
   logic             valid_q, valid_d;
   logic             halted_q, halted_d;
   logic             capture_s;
   logic [OPC_W-1:0] opc_s;

   assign opc_s = instr_in[IW-1 -: OPC_W];

   // Next-state logic: branch beats stall, stall beats a normal capture.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      pc_out_d  = pc_out_q;
      valid_d   = valid_q;
      halted_d  = halted_q;
      capture_s = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (branch_take) begin
               pc_d    = branch_target;
               valid_d = 1'b0;
            end else if (stall) begin
               pc_d = pc_q;
            end else begin
               capture_s = 1'b1;
               instr_d   = instr_in;
               pc_out_d  = pc_q;
               valid_d   = 1'b1;
               // A halt word is still handed to decode, but the PC parks on it.
               if (opc_s == HALT_OPC) begin
                  state_d  = S_HALT;
                  halted_d = 1'b1;
               end else begin
                  pc_d = pc_q + {{(AW-1){1'b0}}, 1'b1};
               end
            end
         end
         S_HALT: begin
            valid_d  = 1'b0;
            halted_d = 1'b1;
         end
         default: begin
            state_d  = S_FETCH;
            valid_d  = 1'b0;
            halted_d = 1'b0;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_PC;
         instr_q  <= {IW{1'b0}};
         pc_out_q <= {AW{1'b0}};
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         pc_out_q <= pc_out_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
      end
   end

   assign pc_addr     = pc_q;
   assign instr_out   = instr_q;
   assign pc_out      = pc_out_q;
   assign instr_valid = valid_q;
   assign halted      = halted_q;

`ifdef FETCH_PERF_EN
   logic [15:0] count_q, count_d;

   // Saturating count of captured words.
   always_comb begin
      count_d = count_q;
      if (capture_s && (count_q != 16'hFFFF)) begin
         count_d = count_q + 16'd1;
      end else begin
         count_d = count_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 16'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign fetch_count = count_q;
`else
   logic unused_capture_s;
   assign unused_capture_s = capture_s;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random stall/branch/reset
// traffic, compared each cycle against a behavioural model of the fetch rules.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        branch_take = 1'b0;
   logic [7:0]  branch_target = 8'h00;
   logic [7:0]  pc_addr;
   logic [16:0] instr_in;
   logic [16:0] instr_out;
   logic [7:0]  pc_out;
   logic        instr_valid;
   logic        halted;
`ifdef FETCH_PERF_EN
   logic [15:0] fetch_count;
`endif

   logic [16:0] mem [256];
   assign instr_in = mem[pc_addr];

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .rst(rst), .stall(stall), .branch_take(branch_take),
      .branch_target(branch_target), .pc_addr(pc_addr), .instr_in(instr_in),
      .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
      .halted(halted)
`ifdef FETCH_PERF_EN
      , .fetch_count(fetch_count)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   int m_pc, m_po, m_cnt;
   logic [16:0] m_io;
   bit m_iv, m_halt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic compare_all();
      check_eq("pc_addr", {24'd0, pc_addr}, m_pc);
      check_eq("instr_out", {15'd0, instr_out}, {15'd0, m_io});
      check_eq("pc_out", {24'd0, pc_out}, m_po);
      check_eq("instr_valid", {31'd0, instr_valid}, {31'd0, m_iv});
      check_eq("halted", {31'd0, halted}, {31'd0, m_halt});
`ifdef FETCH_PERF_EN
      check_eq("fetch_count", {16'd0, fetch_count}, m_cnt);
`endif
   endtask

   // One clock: apply inputs, advance the model by the fetch rules, compare after the edge.
   task automatic step(input bit r, input bit s, input bit b, input logic [7:0] t);
      logic [16:0] w;
      rst = r; stall = s; branch_take = b; branch_target = t;
      w = mem[m_pc];
      @(posedge clk);
      if (r) begin
         m_pc = 0; m_io = 17'h0; m_po = 0; m_iv = 0; m_halt = 0; m_cnt = 0;
      end else if (m_halt) begin
         m_iv = 0;
      end else if (b) begin
         m_pc = t; m_iv = 0;
      end else if (!s) begin
         m_io = w; m_po = m_pc; m_iv = 1;
         if (m_cnt < 65535) m_cnt++;
         if (w[16:12] == 5'h1F) m_halt = 1;
         else m_pc = (m_pc + 1) % 256;
      end
      #1;
      compare_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 17'(i);
      m_pc = 0; m_po = 0; m_cnt = 0; m_io = 17'h0; m_iv = 0; m_halt = 0;
      #1;

      // 1: reset and sequential fetch
      do_reset();
      check_eq("rst_pc", {24'd0, pc_addr}, 32'h0);
      check_eq("rst_valid", {31'd0, instr_valid}, 32'h0);
      check_eq("rst_halted", {31'd0, halted}, 32'h0);
      run(5);
      check_eq("seq_pc", {24'd0, pc_addr}, 32'h5);
      check_eq("seq_lag", {15'd0, instr_out}, 32'h4);

      // 2: stall freezes everything
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
      check_eq("stall_pc", {24'd0, pc_addr}, 32'h5);
      check_eq("stall_instr", {15'd0, instr_out}, 32'h4);
      check_eq("stall_pcout", {24'd0, pc_out}, 32'h4);
      run(1);
      check_eq("resume_instr", {15'd0, instr_out}, 32'h5);

      // 3: branch with one bubble
      run(4);
      check_eq("pre_branch_pc", {24'd0, pc_addr}, 32'hA);
      step(1'b0, 1'b0, 1'b1, 8'h40);
      check_eq("br_pc", {24'd0, pc_addr}, 32'h40);
      check_eq("br_bubble", {31'd0, instr_valid}, 32'h0);
      run(1);
      check_eq("br_instr", {15'd0, instr_out}, 32'h40);
      check_eq("br_pcout", {24'd0, pc_out}, 32'h40);

      // 4: branch beats stall; branch discards a halt word
      step(1'b0, 1'b1, 1'b1, 8'h20);
      check_eq("br_over_stall", {24'd0, pc_addr}, 32'h20);
      mem[3] = 17'h1F000;
      do_reset();
      run(3);
      step(1'b0, 1'b0, 1'b1, 8'h10);
      check_eq("br_over_halt", {31'd0, halted}, 32'h0);
      check_eq("br_over_halt_pc", {24'd0, pc_addr}, 32'h10);

      // 5: halt capture, stall-delayed halt, branch ignored, reset recovery
      do_reset();
      run(3);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check_eq("stall_on_halt", {31'd0, halted}, 32'h0);
      run(1);
      check_eq("halt_instr", {15'd0, instr_out}, 32'h1F000);
      check_eq("halt_valid", {31'd0, instr_valid}, 32'h1);
      check_eq("halt_flag", {31'd0, halted}, 32'h1);
      check_eq("halt_pc", {24'd0, pc_addr}, 32'h3);
      step(1'b0, 1'b0, 1'b1, 8'h80);
      check_eq("halt_br_ign", {24'd0, pc_addr}, 32'h3);
      check_eq("halt_valid_drop", {31'd0, instr_valid}, 32'h0);
      run(2);
      do_reset();
      check_eq("halt_rst", {31'd0, halted}, 32'h0);
      mem[3] = 17'h3;

      // 6: PC wrap
      step(1'b0, 1'b0, 1'b1, 8'hFF);
      run(1);
      check_eq("wrap_pc", {24'd0, pc_addr}, 32'h0);
      check_eq("wrap_pcout", {24'd0, pc_out}, 32'hFF);
      check_eq("wrap_instr", {15'd0, instr_out}, 32'hFF);

      // random traffic over random memory with sparse halt words
      for (int i = 0; i < 256; i++) begin
         logic [16:0] v;
         v = 17'($urandom);
         if ($urandom_range(15, 0) == 0) v[16:12] = 5'h1F;
         else if (v[16:12] == 5'h1F) v[16] = 1'b0;
         mem[i] = v;
      end
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         bit r, s, b;
         r = ($urandom_range(99, 0) < 3);
         s = ($urandom_range(99, 0) < 25);
         b = ($urandom_range(99, 0) < 10);
         step(r, s, b, 8'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
